serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit adder that drives the team's 1-bit full-adder cell one bit per clock.
//  Holds operand shift registers, a carry flip-flop, a bit counter and a start/done handshake.
//  Sits upstream of the full adder, sequencing operand bits into it. Also sits downstream of it,
//  collecting S/Cout into the result word.
//  Area-minimal alternative to the ripple adder, used in the datapath labs.
// PARAMETERS
//  WIDTH    8   operand/result width in bits; legal range 1..32
// PORTS
//  clk      in   1        single clock; all state updates on rising edge
//  rst_n    in   1        asynchronous, active-low reset
//  start    in   1        request; sampled only in IDLE or DONE
//  a        in   WIDTH    operand A; captured on accepted start
//  b        in   WIDTH    operand B; captured on accepted start
//  cin      in   1        carry-in; captured on accepted start
//  busy     out  1        high while in RUN
//  done     out  1        single-cycle pulse: result registers just updated
//  sum      out  WIDTH    registered result; stable between completions
//  cout     out  1        registered final carry-out; stable between completions
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE; busy=0, done=0, sum=0, cout=0.
//   - Internal shift registers, carry and counter all 0.
//  States: IDLE, RUN, DONE.
//   IDLE -> RUN on start=1.
//    - Load sa<=a, sb<=b, carry<=cin, acc<=0, cnt<=0.
//   RUN, every cycle:
//    - fa_bit inputs: sa[0], sb[0], carry.
//    - Shift sa and sb right by 1, zero-filled.
//    - acc <= {S, acc[WIDTH-1:1]}.
//    - carry <= Cout.
//    - cnt <= cnt+1.
//   RUN -> DONE when cnt==WIDTH-1 at the edge.
//    - That edge also loads sum <= {S, acc[WIDTH-1:1]} and cout <= Cout.
//   DONE lasts exactly one cycle, with done=1.
//    - If start=1: reload as above and go to RUN (back-to-back operation).
//    - Otherwise go to IDLE.
//  Latency:
//   - Start accepted at edge k -> done=1 in the cycle after edge k+WIDTH.
//   - Throughput: one add per WIDTH+1 cycles.
//  Handshake:
//   - busy=1 exactly WIDTH cycles per operation.
//   - start while busy is ignored; no queuing.
//   - a/b/cin only need to be valid at the accepting edge.
//  Arithmetic:
//   - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
//  Boundaries:
//   - WIDTH=1: RUN lasts one cycle.
//   - cnt width is $clog2(WIDTH)+1. No wrap-around occurs inside an operation.
//   - Reset mid-RUN aborts: no done pulse; sum/cout return to 0.
//   - Start held high continuously: one operation per WIDTH+1 cycles. IDLE is never re-entered.
//   - sum/cout do not change during RUN; only the completing edge updates them.
// STRUCTURE
//  - Shared package: state enum encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width
//    helper expression. Reused by later serial multiplier and shifter blocks.
//  - One sub-module: fa_bit. Purely combinational 1-bit full adder with ports A, B, C -> S, Cout,
//    written with a complete sensitivity list (all three inputs).
//  - Instantiated once. Everything else (FSM, shifters, counter) lives in this module.
// TESTING
//  1. WIDTH=8; a=8'h05, b=8'h03, cin=0, start 1 cycle.
//     -> busy=1 for 8 cycles; done after 8 edges; sum=8'h08, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0.
//     -> sum=8'h00, cout=1. Confirms the carry ripples through all 8 serial steps.
//  3. a=8'hFF, b=8'hFF, cin=1.
//     -> sum=8'hFF, cout=1.
//     Then a=0, b=0, cin=0 -> sum=0, cout=0.
//  4. Start, then pulse start again at cycle 3 of RUN with a=8'hAA.
//     -> ignored; result is the first operation's; exactly one done pulse.
//  5. start held high; ops (8'h10+8'h20) then (8'h7F+8'h01).
//     -> done 9 cycles apart; sum=8'h30, then 8'h80; no IDLE cycle between them.
//  6. Assert rst_n=0 mid-RUN at cycle 4, asynchronously between edges.
//     -> outputs 0 immediately; no done pulse.
//     After release, a fresh op 8'h01+8'h01 -> sum=8'h02.
//  Self-check: bench compares every done against a+b+cin using a reference model.
//  Random sweep: 1000 random operands at WIDTH=8, plus a WIDTH=1 exhaustive run.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial datapath blocks (adder, multiplier, shifter).
package serial_adder_ctrl_pkg;

    // Sequencer states shared by the serial blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    // Bit-counter width: wide enough to hold WIDTH-1 with one spare bit, so no wrap inside an op
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// 1-bit full adder cell driven one bit per clock by the serial sequencer.
module fa_bit (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic Cout
);

    // Sum and carry from the three input bits
    always @(A or B or C) begin
        S    = A ^ B ^ C;
        Cout = (A & B) | (C & (A ^ B));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: shifts operands LSB-first through one full-adder cell,
// collects the sum bits MSB-first into an accumulator and publishes the word on completion.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t     state, state_nxt;
    logic           load;
    logic [WIDTH-1:0] sa, sb, acc, acc_nxt;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s, fa_cout;

    fa_bit u_fa (
        .A    (sa[0]),
        .B    (sb[0]),
        .C    (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the first-computed LSB
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_nxt = fa_s;
        end else begin : g_acc_wn
            assign acc_nxt = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and operand-load request; start is only honoured outside RUN
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, serial shift/accumulate, result publish on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            acc   <= acc_nxt;
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
                sum  <= acc_nxt;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1, a1, b1, cin1;
    logic       busy1, done1, sum1, cout1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic over WIDTH+1 bits
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // Called on the negedge after the accepting edge; returns cycles until done is seen
    task automatic wait_done(output int cyc, output int bcyc, output bit sum_moved);
        logic [7:0] s0;
        logic       c0;
        s0 = sum; c0 = cout;
        cyc = 0; bcyc = 0; sum_moved = 0;
        while (!done && cyc < 100) begin
            if (busy) bcyc++;
            if (sum !== s0 || cout !== c0) sum_moved = 1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) chk("done_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          input logic [7:0] es, input logic ec, input string nm);
        int cyc, bcyc;
        bit moved;
        @(negedge clk);
        start = 1'b1; a = xa; b = xb; cin = xc;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
        wait_done(cyc, bcyc, moved);
        chk({nm, "_latency"}, 32'(cyc), 32'd8);
        chk({nm, "_busy_cycles"}, 32'(bcyc), 32'd8);
        chk({nm, "_sum_stable"}, 32'(moved), 32'd0);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, bcyc, extra;
        bit moved;
        logic [8:0] r;
        logic [1:0] r1;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 4; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, $sformatf("vec%0d", i));

        // Start pulse during RUN is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy_c3", 32'(busy), 32'd1);
        start = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcyc, moved);
        chk("t4_latency", 32'(cyc + 3), 32'd8);
        chk("t4_sum", 32'(sum), 32'h46);
        chk("t4_cout", 32'(cout), 32'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("t4_single_done", 32'(extra), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back ops with no IDLE gap
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        a = 8'h7F; b = 8'h01;
        wait_done(cyc, bcyc, moved);
        chk("t5_lat1", 32'(cyc), 32'd8);
        chk("t5_sum1", 32'(sum), 32'h30);
        @(negedge clk);
        chk("t5_no_idle", 32'(busy), 32'd1);
        wait_done(cyc, bcyc, moved);
        chk("t5_spacing", 32'(cyc + 1), 32'd9);
        chk("t5_sum2", 32'(sum), 32'h80);
        chk("t5_cout2", 32'(cout), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("t5_idle_after", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_c4", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_sum",  32'(sum),  32'd0);
        chk("t6_rst_cout", 32'(cout), 32'd0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("t6_no_done", 32'(extra), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "t6_fresh");

        // Random sweep against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            r  = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, r[7:0], r[8], "rnd");
        end

        // WIDTH=1 exhaustive
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            r1 = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
            @(negedge clk);
            start1 = 1'b1; a1 = vv[2]; b1 = vv[1]; cin1 = vv[0];
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1_busy_%0d", v), 32'(busy1), 32'd1);
            chk($sformatf("w1_sum_hold_%0d", v), 32'(done1), 32'd0);
            @(negedge clk);
            chk($sformatf("w1_done_%0d", v), 32'(done1), 32'd1);
            chk($sformatf("w1_sum_%0d", v), 32'(sum1), 32'(r1[0]));
            chk($sformatf("w1_cout_%0d", v), 32'(cout1), 32'(r1[1]));
            @(negedge clk);
            chk($sformatf("w1_pulse_%0d", v), 32'(done1), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
